// File: rtl/bn_pkg.sv
// bn_pkg: shared factor codes, term-select codes and counter width for batch_norm_pipeline.
package bn_pkg;
    typedef logic [3:0] bn_factor_t;
    localparam bn_factor_t BN_FACTOR_UNITY = 4'b0100;
    localparam bn_factor_t BN_FACTOR_ZERO  = 4'b0000;
    localparam logic [1:0] BN_LO_NONE    = 2'b00;
    localparam logic [1:0] BN_LO_HALF    = 2'b01;
    localparam logic [1:0] BN_LO_X2      = 2'b10;
    localparam logic [1:0] BN_LO_X8      = 2'b11;
    localparam logic [1:0] BN_HI_NONE    = 2'b00;
    localparam logic [1:0] BN_HI_X1      = 2'b01;
    localparam logic [1:0] BN_HI_QUARTER = 2'b10;
    localparam logic [1:0] BN_HI_X4      = 2'b11;
    localparam int BN_SAT_COUNT_WIDTH = 16;
endpackage

// File: rtl/bn_scale_term.sv
// bn_scale_term: decodes a 4-bit factor code into factor*z as two shifted terms,
// sign-extended to WIDTH+5 bits so no code can overflow.
module bn_scale_term import bn_pkg::*; #(
    parameter int WIDTH = 6
) (
    input  logic [3:0]              i_factor,
    input  logic signed [WIDTH-1:0] i_z,
    output logic signed [WIDTH+4:0] o_term
);
    localparam int SW = WIDTH + 5;
    logic signed [SW-1:0] w_z, w_half, w_quarter, w_lo, w_hi;
    assign w_z       = {{5{i_z[WIDTH-1]}}, i_z};
    assign w_half    = w_z >>> 1;
    assign w_quarter = w_z >>> 2;
    assign w_lo = (i_factor[1:0] == BN_LO_HALF) ? w_half :
                  (i_factor[1:0] == BN_LO_X2)   ? (w_z <<< 1) :
                  (i_factor[1:0] == BN_LO_X8)   ? (w_z <<< 3) : '0;
    assign w_hi = (i_factor[3:2] == BN_HI_X1)      ? w_z :
                  (i_factor[3:2] == BN_HI_QUARTER) ? w_quarter :
                  (i_factor[3:2] == BN_HI_X4)      ? (w_z <<< 2) : '0;
    assign o_term = w_lo + w_hi;
endmodule

// File: rtl/batch_norm_pipeline.sv
// batch_norm_pipeline: 2-stage u + addend[ch] + factor[ch]*z with saturation and valid/ready.
// Optional saturation event counter enabled by defining BN_SAT_COUNT_EN.
module batch_norm_pipeline import bn_pkg::*; #(
    parameter int WIDTH        = 6,
    parameter int ADDEND_WIDTH = WIDTH - 2,
    parameter int CHANNELS     = 4,
    parameter int CH_BITS      = $clog2(CHANNELS)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    cfg_we,
    input  logic [CH_BITS-1:0]      cfg_ch,
    input  logic [3:0]              cfg_factor,
    input  logic [ADDEND_WIDTH-1:0] cfg_addend,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [CH_BITS-1:0]      in_ch,
    input  logic [WIDTH-1:0]        in_u,
    input  logic [WIDTH-1:0]        in_z,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [CH_BITS-1:0]      out_ch,
    output logic [WIDTH-1:0]        out_u
`ifdef BN_SAT_COUNT_EN
    ,
    input  logic                    sat_clr,
    output logic [BN_SAT_COUNT_WIDTH-1:0] sat_count
`endif
);
    localparam int SW = WIDTH + 5;
    localparam logic signed [SW-1:0] MAX_V = {{(SW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic signed [SW-1:0] MIN_V = {{(SW-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

    logic [3:0]              r_factor [CHANNELS];
    logic [ADDEND_WIDTH-1:0] r_addend [CHANNELS];
    logic                    r_s1_valid, r_out_valid;
    logic [CH_BITS-1:0]      r_s1_ch, r_out_ch;
    logic [WIDTH-1:0]        r_s1_u, r_out_u;
    logic [ADDEND_WIDTH-1:0] r_s1_addend;
    logic signed [SW-1:0]    r_s1_term;

    logic                    w_in_ok, w_s2_adv, w_clamp_hi, w_clamp_lo;
    logic [3:0]              w_factor;
    logic [ADDEND_WIDTH-1:0] w_addend;
    logic signed [SW-1:0]    w_term, w_sum;
    logic [WIDTH-1:0]        w_sat;

    // Out-of-range channels behave as factor 0000 / addend 0
    assign w_in_ok  = int'(in_ch) < CHANNELS;
    assign w_factor = w_in_ok ? r_factor[in_ch] : BN_FACTOR_ZERO;
    assign w_addend = w_in_ok ? r_addend[in_ch] : '0;

    bn_scale_term #(.WIDTH(WIDTH)) u_scale_term (
        .i_factor(w_factor),
        .i_z     (in_z),
        .o_term  (w_term)
    );

    assign w_s2_adv  = !r_out_valid || out_ready;
    assign in_ready  = !r_s1_valid || w_s2_adv;
    assign out_valid = r_out_valid;
    assign out_ch    = r_out_ch;
    assign out_u     = r_out_u;

    assign w_sum = {{(SW-WIDTH){r_s1_u[WIDTH-1]}}, r_s1_u}
                 + {{(SW-ADDEND_WIDTH){r_s1_addend[ADDEND_WIDTH-1]}}, r_s1_addend}
                 + r_s1_term;
    assign w_clamp_hi = w_sum > MAX_V;
    assign w_clamp_lo = w_sum < MIN_V;
    assign w_sat = w_clamp_hi ? {1'b0, {(WIDTH-1){1'b1}}} :
                   w_clamp_lo ? {1'b1, {(WIDTH-1){1'b0}}} : w_sum[WIDTH-1:0];

    // Writes land at the clock edge, so an accept in the same cycle still sees old values
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < CHANNELS; i++) begin
                r_factor[i] <= BN_FACTOR_UNITY;
                r_addend[i] <= '0;
            end
        end else if (cfg_we && int'(cfg_ch) < CHANNELS) begin
            r_factor[cfg_ch] <= cfg_factor;
            r_addend[cfg_ch] <= cfg_addend;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid  <= 1'b0;
            r_s1_ch     <= '0;
            r_s1_u      <= '0;
            r_s1_addend <= '0;
            r_s1_term   <= '0;
        end else if (in_ready) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_s1_ch     <= in_ch;
                r_s1_u      <= in_u;
                r_s1_addend <= w_addend;
                r_s1_term   <= w_term;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_ch    <= '0;
            r_out_u     <= '0;
        end else if (w_s2_adv) begin
            r_out_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_out_ch <= r_s1_ch;
                r_out_u  <= w_sat;
            end
        end
    end

`ifdef BN_SAT_COUNT_EN
    logic                          r_out_sat;
    logic [BN_SAT_COUNT_WIDTH-1:0] r_sat_count;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_sat   <= 1'b0;
            r_sat_count <= '0;
        end else begin
            if (w_s2_adv && r_s1_valid)
                r_out_sat <= w_clamp_hi || w_clamp_lo;
            if (sat_clr)
                r_sat_count <= '0;
            else if (r_out_valid && out_ready && r_out_sat && r_sat_count != '1)
                r_sat_count <= r_sat_count + 1'b1;
        end
    end
    assign sat_count = r_sat_count;
`endif
endmodule

// File: tb/tb_batch_norm_pipeline.sv
// tb_batch_norm_pipeline: scoreboard bench with an arithmetic reference model of the
// batch-norm unit; covers BN_SAT_COUNT_EN when that macro is defined.
module tb_batch_norm_pipeline;
    typedef struct {
        int ch;
        int u;
        bit sat;
    } exp_t;

    logic       clk, rst_n, cfg_we, in_valid, in_ready, out_valid, out_ready;
    logic [1:0] cfg_ch, in_ch, out_ch;
    logic [3:0] cfg_factor, cfg_addend;
    logic [5:0] in_u, in_z, out_u;
`ifdef BN_SAT_COUNT_EN
    logic        sat_clr;
    logic [15:0] sat_count;
`endif

    int   n_checks = 0;
    int   n_fail = 0;
    int   m_f [4];
    int   m_a [4];
    int   m_sat = 0;
    exp_t q [$];
    bit   m_held = 0;
    int   h_u, h_ch;
    bit   dropped = 0;
    bit   stop = 0;

    batch_norm_pipeline dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cfg_we    (cfg_we),
        .cfg_ch    (cfg_ch),
        .cfg_factor(cfg_factor),
        .cfg_addend(cfg_addend),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_ch     (in_ch),
        .in_u      (in_u),
        .in_z      (in_z),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ch    (out_ch),
        .out_u     (out_u)
`ifdef BN_SAT_COUNT_EN
        ,
        .sat_clr   (sat_clr),
        .sat_count (sat_count)
`endif
    );

    initial clk = 0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int floor_div(input int z, input int d);
        return $rtoi($floor(real'(z) / real'(d)));
    endfunction

    // result = sat(u + addend + factor*z), factor = low term + high term
    function automatic exp_t model(input int ch, input int u, input int z);
        exp_t e;
        int f, s;
        f = m_f[ch];
        s = u + m_a[ch];
        case (f % 4)
            1: s += floor_div(z, 2);
            2: s += 2 * z;
            3: s += 8 * z;
            default: ;
        endcase
        case (f / 4)
            1: s += z;
            2: s += floor_div(z, 4);
            3: s += 4 * z;
            default: ;
        endcase
        e.ch  = ch;
        e.sat = (s > 31) || (s < -32);
        e.u   = (s > 31) ? 31 : (s < -32) ? -32 : s;
        return e;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_f[i] = 4;
            m_a[i] = 0;
        end
    endtask

    always @(negedge rst_n) begin
        q.delete();
        model_reset();
        m_held = 0;
        m_sat = 0;
    end

    // Monitor: everything sampled here takes effect at the following rising edge
    always @(negedge clk) begin
        exp_t e;
        bit   hs_sat;
        if (rst_n) begin
            hs_sat = 0;
            if (m_held) begin
                chk("hold_valid", int'(out_valid), 1);
                chk("hold_u", $signed(out_u), h_u);
                chk("hold_ch", int'(out_ch), h_ch);
            end
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_output: got ch=%0d u=%0d expected none", out_ch, $signed(out_u));
                end else begin
                    e = q.pop_front();
                    chk("out_ch", int'(out_ch), e.ch);
                    chk("out_u", $signed(out_u), e.u);
                    hs_sat = e.sat;
                end
            end
`ifdef BN_SAT_COUNT_EN
            if (sat_clr) m_sat = 0;
            else if (hs_sat && m_sat < 65535) m_sat++;
`endif
            m_held = out_valid && !out_ready;
            h_u = $signed(out_u);
            h_ch = int'(out_ch);
            if (in_valid && in_ready)
                q.push_back(model(int'(in_ch), $signed(in_u), $signed(in_z)));
            if (cfg_we) begin
                m_f[cfg_ch] = int'(cfg_factor);
                m_a[cfg_ch] = $signed(cfg_addend);
            end
        end
    end

    task automatic send(input int ch, input int u, input int z);
        int k;
        in_valid = 1;
        in_ch = 2'(ch);
        in_u = 6'(u);
        in_z = 6'(z);
        k = 0;
        @(negedge clk);
        while (!in_ready && k < 50) begin
            k++;
            @(negedge clk);
        end
        if (!in_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout: got in_ready=0 expected 1 within 50 cycles");
        end
        @(posedge clk);
        #1 in_valid = 0;
    endtask

    task automatic cfg(input int ch, input int f, input int a);
        cfg_we = 1;
        cfg_ch = 2'(ch);
        cfg_factor = 4'(f);
        cfg_addend = 4'(a);
        @(posedge clk);
        #1 cfg_we = 0;
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (q.size() != 0 && k < 100) begin
            k++;
            @(negedge clk);
        end
        if (q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain_timeout: got %0d pending expected 0", q.size());
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 0; cfg_we = 0; cfg_ch = 0; cfg_factor = 0; cfg_addend = 0;
        in_valid = 0; in_ch = 0; in_u = 0; in_z = 0; out_ready = 1;
`ifdef BN_SAT_COUNT_EN
        sat_clr = 0;
`endif
        model_reset();
        repeat (3) @(posedge clk);
        #1 rst_n = 1;
        @(negedge clk);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_u", int'(out_u), 0);
        chk("rst_out_ch", int'(out_ch), 0);
        chk("rst_in_ready", int'(in_ready), 1);
`ifdef BN_SAT_COUNT_EN
        chk("rst_sat_count", int'(sat_count), 0);
`endif
        @(posedge clk);
        #1;
        send(0, 5, 3);
        @(negedge clk);
        chk("latency_cycle1", int'(out_valid), 0);
        @(negedge clk);
        chk("latency_cycle2", int'(out_valid), 1);
        chk("first_result", $signed(out_u), 8);
        @(posedge clk);
        #1;
        cfg(1, 4'b0001, -2);
        send(1, 10, -3);
        cfg(2, 4'b1100, 0);
        send(2, 20, 5);
        cfg(0, 4'b1111, 0);
        send(0, -32, -8);
        drain();
`ifdef BN_SAT_COUNT_EN
        chk("sat_count_directed", int'(sat_count), m_sat);
        sat_clr = 1;
        @(posedge clk);
        #1 sat_clr = 0;
        chk("sat_count_cleared", int'(sat_count), 0);
`endif
        cfg_we = 1; cfg_ch = 3; cfg_factor = 4'b0010; cfg_addend = 0;
        in_valid = 1; in_ch = 3; in_u = 6'd1; in_z = 6'd2;
        @(negedge clk);
        chk("same_cycle_ready", int'(in_ready), 1);
        @(posedge clk);
        #1 cfg_we = 0;
        in_valid = 0;
        send(3, 1, 2);
        drain();
        for (int c = 0; c < 4; c++)
            cfg(c, $urandom_range(0, 15), $urandom_range(0, 15));
        fork
            begin
                for (int i = 0; i < 8; i++)
                    send($urandom_range(0, 3), $urandom_range(0, 63) - 32, $urandom_range(0, 63) - 32);
            end
            begin
                repeat (3) @(posedge clk);
                #1 out_ready = 0;
                repeat (3) begin
                    @(negedge clk);
                    if (!in_ready) dropped = 1;
                end
                @(posedge clk);
                #1 out_ready = 1;
            end
        join
        chk("stall_in_ready_dropped", int'(dropped), 1);
        drain();
        fork
            begin
                for (int i = 0; i < 60; i++) begin
                    if ($urandom_range(0, 3) == 0)
                        cfg($urandom_range(0, 3), $urandom_range(0, 15), $urandom_range(0, 15));
                    if ($urandom_range(0, 3) == 0) begin
                        @(posedge clk);
                        #1;
                    end
                    send($urandom_range(0, 3), $urandom_range(0, 63) - 32, $urandom_range(0, 63) - 32);
                end
                stop = 1;
            end
            begin
                while (!stop) begin
                    @(posedge clk);
                    #1 out_ready = ($urandom_range(0, 2) != 0);
                end
                out_ready = 1;
            end
        join
        drain();
`ifdef BN_SAT_COUNT_EN
        chk("sat_count_random", int'(sat_count), m_sat);
`endif
        out_ready = 0;
        send(1, 4, 4);
        send(2, 4, 4);
        rst_n = 0;
        #1;
        chk("midrst_out_valid", int'(out_valid), 0);
        out_ready = 1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        repeat (4) begin
            @(negedge clk);
            chk("midrst_no_stale", int'(out_valid), 0);
        end
        @(posedge clk);
        #1;
        send(1, 3, 4);
        send(2, 3, 4);
        @(negedge clk);
        @(negedge clk);
        chk("midrst_params_unity", $signed(out_u), 7);
        drain();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
